// File: rtl/miriscv_lsu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : miriscv_lsu_pkg
// Purpose  : Shared types for the load/store unit: access size encoding,
//            tracking-FIFO entry layout and the load extension helper.
// Revision : 1.0
// ============================================================================
package miriscv_lsu_pkg;

    localparam int XLEN         = 32;
    localparam int MEM_ACCESS_W = 3;

    typedef enum logic [MEM_ACCESS_W-1:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5
    } mem_size_e;

    // killed must remain the LSB: the tracking FIFO flags entries through bit 0.
    typedef struct packed {
        logic                    we;
        logic [MEM_ACCESS_W-1:0] size;
        logic [1:0]              offset;
        logic                    killed;
    } lsu_track_t;

    function automatic logic [XLEN-1:0] lsu_load_extend(
        input logic [MEM_ACCESS_W-1:0] size,
        input logic [1:0]              offset,
        input logic [XLEN-1:0]         rdata
    );
        logic [XLEN-1:0] w_sh;
        w_sh = rdata >> {offset, 3'b000};
        case (size)
            MEM_B:   return {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
            MEM_BU:  return {{(XLEN-8){1'b0}}, w_sh[7:0]};
            MEM_H:   return {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
            MEM_HU:  return {{(XLEN-16){1'b0}}, w_sh[15:0]};
            default: return rdata;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/miriscv_lsu_track_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : miriscv_lsu_track_fifo
// Purpose  : In-order tracking FIFO for outstanding memory requests with a
//            bulk kill that flags every occupied entry (entry bit 0).
// Revision : 1.0
// ============================================================================
module miriscv_lsu_track_fifo #(
    parameter int  DEPTH   = 2,
    parameter type ENTRY_T = logic [7:0],
    parameter int  CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             i_push,
    input  ENTRY_T           i_push_entry,
    input  logic             i_pop,
    input  logic             i_kill_all,
    output ENTRY_T           o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int               PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(DEPTH - 1);

    ENTRY_T           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic [DEPTH-1:0] w_occupied;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CNT_W'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_head  = r_mem[r_rptr];
    assign o_count = r_cnt;

    // Entry i is live when its distance from the read pointer is below count.
    always_comb begin
        w_occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occupied[i] = (((i >= int'(r_rptr)) ? (i - int'(r_rptr))
                                                  : (i + DEPTH - int'(r_rptr))) < int'(r_cnt));
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill_all && w_occupied[i]) r_mem[i][0] <= 1'b1;
            end
            if (w_push) begin
                r_mem[r_wptr] <= i_push_entry;
                r_wptr        <= f_inc(r_wptr);
            end
            if (w_pop) r_rptr <= f_inc(r_rptr);
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (arstn_i && i_pop) begin
            assert (!w_empty) else $warning("track_fifo: response with nothing outstanding, ignored");
        end
    end

endmodule
`default_nettype wire

// File: rtl/miriscv_lsu_mo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : miriscv_lsu_mo
// Purpose  : Load/store unit with multiple outstanding requests, misalignment
//            check, in-order response tracking and flush support.
// Revision : 1.0
// ============================================================================
module miriscv_lsu_mo
    import miriscv_lsu_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter bit EN_MISALIGN_CHK = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic                    lsu_req_i,
    input  logic                    lsu_kill_i,
    input  logic                    lsu_we_i,
    input  logic [MEM_ACCESS_W-1:0] lsu_size_i,
    input  logic [XLEN-1:0]         lsu_addr_i,
    input  logic [XLEN-1:0]         lsu_data_i,
    output logic                    lsu_stall_o,
    output logic                    lsu_misaligned_o,
    output logic                    lsu_rsp_valid_o,
    output logic [XLEN-1:0]         lsu_rsp_data_o,
    output logic                    lsu_busy_o,
    output logic                    data_req_o,
    output logic                    data_we_o,
    output logic [XLEN/8-1:0]       data_be_o,
    output logic [XLEN-1:0]         data_addr_o,
    output logic [XLEN-1:0]         data_wdata_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic [XLEN-1:0]         data_rdata_i
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0] w_count;
    lsu_track_t       w_head;
    lsu_track_t       w_push_entry;
    logic             w_misaligned;
    logic             w_busy;
    logic             w_issue;
    logic             w_handshake;
    logic             w_pop;

    always_comb begin
        w_misaligned = 1'b0;
        if (EN_MISALIGN_CHK) begin
            if ((lsu_size_i == MEM_H || lsu_size_i == MEM_HU) && lsu_addr_i[0])
                w_misaligned = 1'b1;
            if (lsu_size_i == MEM_W && lsu_addr_i[1:0] != 2'b00)
                w_misaligned = 1'b1;
        end
    end

    always_comb begin
        case (lsu_size_i)
            MEM_B, MEM_BU: begin
                data_be_o    = 4'b0001 << lsu_addr_i[1:0];
                data_wdata_o = {4{lsu_data_i[7:0]}};
            end
            MEM_H, MEM_HU: begin
                data_be_o    = 4'b0011 << lsu_addr_i[1:0];
                data_wdata_o = {2{lsu_data_i[15:0]}};
            end
            default: begin
                data_be_o    = 4'b1111;
                data_wdata_o = lsu_data_i;
            end
        endcase
    end

    // Every control output is forced low while reset is held.
    assign w_busy           = (w_count != '0);
    assign w_issue          = arstn_i & lsu_req_i & ~lsu_kill_i & ~w_misaligned;
    assign data_req_o       = w_issue & ((w_count < CNT_W'(MAX_OUTSTANDING)) | data_rvalid_i);
    assign w_handshake      = data_req_o & data_gnt_i;
    assign lsu_stall_o      = w_issue & ~w_handshake;
    assign lsu_misaligned_o = arstn_i & lsu_req_i & w_misaligned;
    assign data_we_o        = data_req_o & lsu_we_i;
    assign data_addr_o      = {lsu_addr_i[XLEN-1:2], 2'b00};
    assign lsu_busy_o       = w_busy;

    assign w_push_entry = '{we: lsu_we_i, size: lsu_size_i, offset: lsu_addr_i[1:0], killed: 1'b0};

    // A response popping in the kill cycle is suppressed alongside flagged ones.
    assign w_pop           = data_rvalid_i & w_busy;
    assign lsu_rsp_valid_o = w_pop & ~w_head.we & ~w_head.killed & ~lsu_kill_i;
    assign lsu_rsp_data_o  = lsu_rsp_valid_o ? lsu_load_extend(w_head.size, w_head.offset, data_rdata_i)
                                             : '0;

    miriscv_lsu_track_fifo #(
        .DEPTH   (MAX_OUTSTANDING),
        .ENTRY_T (lsu_track_t),
        .CNT_W   (CNT_W)
    ) u_track_fifo (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .i_push       (w_handshake),
        .i_push_entry (w_push_entry),
        .i_pop        (data_rvalid_i),
        .i_kill_all   (lsu_kill_i),
        .o_head       (w_head),
        .o_count      (w_count)
    );

endmodule
`default_nettype wire
